collision_probe_array: RTL and testbench
========================================

// Module: collision_probe_array
// PURPOSE
//  Multi-object terrain collision detector. It samples the terrain column stream during
//  raster scan-out and builds per-object D/U/L/R contact flags over one whole frame.
//  At frame end it publishes them as a coherent, registered set.
//  Sits between the terrain column memory/scanout and the game-state / physics FSM.
//  Replaces per-sprite single-pixel probes with banded probes and screen-edge handling.
// PARAMETERS
//  NUM_OBJ  4    number of independent objects (probe lanes)
//  COORD_W  10   width of X/Y/radius/DrawX
//  COL_H    512  terrain column height in bits; bit i = row i, 1 = solid
//  SCR_W    640  visible columns; DrawX range 0..SCR_W-1
//  PROBE_D  2    D/U probe band depth in rows (1 = single-pixel probe)
//  SIDE_H   0    L/R band half-height: rows Y-SIDE_H..Y+SIDE_H (0 = single row)
// PORTS
//  clk          in  1                clock
//  reset        in  1                synchronous, active-high
//  frame_start  in  1                pulse; begin accumulation, snapshot object inputs
//  frame_end    in  1                pulse; close accumulation, publish results
//  col_valid    in  1                terrain_data/DrawX valid this cycle (one column)
//  DrawX        in  COORD_W          column index of terrain_data
//  terrain_data in  COL_H            solid map of column DrawX
//  obj_x        in  NUM_OBJ*COORD_W  object centre X; lane n = [n*COORD_W +: COORD_W]
//  obj_y        in  NUM_OBJ*COORD_W  object centre Y
//  obj_radius   in  NUM_OBJ*COORD_W  half-size
//  obj_en       in  NUM_OBJ          lane enable; a disabled lane reports all-zero
//  hit_d/u/l/r  out NUM_OBJ          per-lane contact flags, held between publishes
//  results_valid out 1               1-cycle pulse when hit_* updated
//  busy         out 1                1 while state is SCAN
// BEHAVIOUR
//  Reset: state IDLE, all accumulators 0, hit_* 0, results_valid 0, busy 0.
//  Reset takes effect mid-frame with no publish.
//  FSM: IDLE --frame_start--> SCAN --frame_end--> LATCH --> IDLE.
//   LATCH lasts one cycle. frame_start in LATCH goes straight to SCAN.
//   frame_start in SCAN: clears accumulators, re-snapshots, stays in SCAN, no publish.
//   frame_end in IDLE/LATCH: ignored.
//   frame_start and frame_end in the same SCAN cycle: publish, then go to SCAN (restart).
//  Snapshot: obj_x/y/radius/en are registered on frame_start. Later input changes do not
//   affect the current frame.
//  Per col_valid cycle in SCAN, for each enabled lane (sticky OR into accumulator):
//   DrawX==X:        acc_d |= OR terrain[Y+r .. Y+r+PROBE_D-1]
//                    acc_u |= OR terrain[Y-r-PROBE_D+1 .. Y-r]
//   DrawX==X-r:      acc_l |= OR terrain[Y-SIDE_H .. Y+SIDE_H]
//   DrawX==X+r:      acc_r |= OR terrain[Y-SIDE_H .. Y+SIDE_H]
//   col_valid with frame_start in the same cycle: the column is discarded.
//  Width rules: all sums and differences use COORD_W+1 bits, signed.
//   Any D/U band row <0 or >=COL_H counts as solid (floor/ceiling).
//   L/R band rows outside 0..COL_H-1 are ignored.
//   X-r<0 forces acc_l=1. X+r>=SCR_W forces acc_r=1. These are applied at snapshot.
//  Latency: frame_end sampled in cycle T -> hit_* = acc_* and results_valid=1 in T+1.
//   results_valid is 0 in every other cycle.
//  Disabled lane: accumulator forced 0, published 0.
//  Legacy compatibility: PROBE_D=1, SIDE_H=0, on-screen object gives the old
//   single-pixel D/U/L/R semantics.
// STRUCTURE
//  collider_pkg: typedef enum {S_IDLE,S_SCAN,S_LATCH} state_t; typedef enum {DIR_D,DIR_U,
//   DIR_L,DIR_R} dir_t; coord_t (COORD_W+1 signed); helper function band_or(data,lo,hi).
//  Sub-module collision_probe_lane: one lane (snapshot regs, 4 accumulators, edge forcing).
//   The top level holds the FSM, NUM_OBJ generate instances, and the output registers.
// TESTING
//  1 Legacy: lane0 X=100 Y=200 r=8, solid bit 208 in col 100 only, full frame
//    -> hit_d[0]=1, u/l/r=0, results_valid one cycle after frame_end.
//  2 Bands: PROBE_D=2, solid bit 209 only -> hit_d=1. Same with PROBE_D=1 -> hit_d=0.
//  3 Edges: X=4 r=8 -> hit_l=1 with empty terrain. Y=5 r=8 -> hit_u=1.
//    Y=508 r=8 -> hit_d=1.
//  4 Snapshot: change obj_x 100->300 mid-SCAN; solid only at col 92 row 200
//    -> hit_l=1, using X=100.
//  5 Control: frame_start mid-SCAN clears prior hits (no pulse). frame_end in IDLE
//    -> no pulse. Reset mid-SCAN -> all outputs 0.
//  6 Multi-lane: 4 lanes, lane2 obj_en=0 on solid terrain -> hit_*[2]=0;
//    other lanes independent and correct.

Source files
------------

// File: rtl/collision_probe_array_pkg.sv
// +--------------------------------------------------------------------------+
// | collider_pkg : shared types and the band-reduction helper for the         |
// |                terrain collision probe array.                             |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

package collider_pkg;

    localparam int COORD_W   = 10;
    localparam int MAX_COL_H = 1024;
    localparam int MAX_ROW_W = 10;
    localparam int MAX_BAND  = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_D = 2'd0,
        DIR_U = 2'd1,
        DIR_L = 2'd2,
        DIR_R = 2'd3
    } dir_t;

    typedef logic signed [COORD_W:0] coord_t;

    // OR of rows lo..hi of one column; rows off the column count as oob_solid.
    function automatic logic band_or(input logic [MAX_COL_H-1:0] data,
                                     input int                   lo,
                                     input int                   hi,
                                     input int                   col_h,
                                     input logic                 oob_solid);
        logic res;
        int   row;
        res = 1'b0;
        for (int k = 0; k < MAX_BAND; k++) begin
            row = lo + k;
            if (row <= hi) begin
                if (row < 0 || row >= col_h) begin
                    res = res | oob_solid;
                end else begin
                    res = res | data[row[MAX_ROW_W-1:0]];
                end
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/collision_probe_array_if.sv
// +--------------------------------------------------------------------------+
// | collision_probe_array_if : frame control, terrain stream, object inputs  |
// |                            and published contact flags.                  |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

interface collision_probe_array_if #(
    parameter int NUM_OBJ = 4,
    parameter int COORD_W = 10,
    parameter int COL_H   = 512
);
    logic                       frame_start;
    logic                       frame_end;
    logic                       col_valid;
    logic [COORD_W-1:0]         DrawX;
    logic [COL_H-1:0]           terrain_data;
    logic [NUM_OBJ*COORD_W-1:0] obj_x;
    logic [NUM_OBJ*COORD_W-1:0] obj_y;
    logic [NUM_OBJ*COORD_W-1:0] obj_radius;
    logic [NUM_OBJ-1:0]         obj_en;
    logic [NUM_OBJ-1:0]         hit_d;
    logic [NUM_OBJ-1:0]         hit_u;
    logic [NUM_OBJ-1:0]         hit_l;
    logic [NUM_OBJ-1:0]         hit_r;
    logic                       results_valid;
    logic                       busy;

    modport slave (
        input  frame_start, frame_end, col_valid, DrawX, terrain_data,
               obj_x, obj_y, obj_radius, obj_en,
        output hit_d, hit_u, hit_l, hit_r, results_valid, busy
    );

    modport master (
        output frame_start, frame_end, col_valid, DrawX, terrain_data,
               obj_x, obj_y, obj_radius, obj_en,
        input  hit_d, hit_u, hit_l, hit_r, results_valid, busy
    );
endinterface

`default_nettype wire

// File: rtl/collision_probe_array_lane.sv
// +--------------------------------------------------------------------------+
// | collision_probe_lane : one object lane - snapshot registers, D/U/L/R      |
// |                        sticky accumulators and screen-edge forcing.       |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module collision_probe_lane
    import collider_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int COL_H   = 512,
    parameter int SCR_W   = 640,
    parameter int PROBE_D = 2,
    parameter int SIDE_H  = 0
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               snap,
    input  wire logic               sample,
    input  wire logic [COORD_W-1:0] obj_x,
    input  wire logic [COORD_W-1:0] obj_y,
    input  wire logic [COORD_W-1:0] obj_radius,
    input  wire logic               obj_en,
    input  wire logic [COORD_W-1:0] draw_x,
    input  wire logic [COL_H-1:0]   terrain_data,
    output logic [3:0]              acc
);
    typedef logic signed [COORD_W:0] scoord_t;

    localparam scoord_t C_PD_M1 = scoord_t'(PROBE_D - 1);
    localparam scoord_t C_SIDE  = scoord_t'(SIDE_H);
    localparam scoord_t C_SCR_W = scoord_t'(SCR_W);

    function automatic scoord_t sx(input logic [COORD_W-1:0] v);
        return signed'({1'b0, v});
    endfunction

    logic [COORD_W-1:0] x_q, x_d, y_q, y_d, r_q, r_d;
    logic               en_q, en_d;
    logic [3:0]         acc_q, acc_d;

    scoord_t w_x, w_y, w_r, w_dx;
    scoord_t w_xl, w_xr, w_dlo, w_dhi, w_ulo, w_uhi, w_slo, w_shi;
    scoord_t w_in_xl, w_in_xr;
    logic [MAX_COL_H-1:0] w_col;
    logic [3:0]           w_hit;

    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        r_d  = r_q;
        en_d = en_q;
        if (snap) begin
            x_d  = obj_x;
            y_d  = obj_y;
            r_d  = obj_radius;
            en_d = obj_en;
        end

        w_x   = sx(x_q);
        w_y   = sx(y_q);
        w_r   = sx(r_q);
        w_dx  = sx(draw_x);
        w_xl  = w_x - w_r;
        w_xr  = w_x + w_r;
        w_dlo = w_y + w_r;
        w_dhi = w_dlo + C_PD_M1;
        w_uhi = w_y - w_r;
        w_ulo = w_uhi - C_PD_M1;
        w_slo = w_y - C_SIDE;
        w_shi = w_y + C_SIDE;
        w_col = MAX_COL_H'(terrain_data);

        // D/U bands treat off-column rows as floor/ceiling; side bands ignore them.
        w_hit        = '0;
        w_hit[DIR_D] = (w_dx == w_x)  && band_or(w_col, int'(w_dlo), int'(w_dhi), COL_H, 1'b1);
        w_hit[DIR_U] = (w_dx == w_x)  && band_or(w_col, int'(w_ulo), int'(w_uhi), COL_H, 1'b1);
        w_hit[DIR_L] = (w_dx == w_xl) && band_or(w_col, int'(w_slo), int'(w_shi), COL_H, 1'b0);
        w_hit[DIR_R] = (w_dx == w_xr) && band_or(w_col, int'(w_slo), int'(w_shi), COL_H, 1'b0);

        w_in_xl = sx(obj_x) - sx(obj_radius);
        w_in_xr = sx(obj_x) + sx(obj_radius);

        acc_d = acc_q;
        if (snap) begin
            acc_d        = '0;
            acc_d[DIR_L] = obj_en && (w_in_xl < 0);
            acc_d[DIR_R] = obj_en && (w_in_xr >= C_SCR_W);
        end else if (sample && en_q) begin
            acc_d = acc_q | w_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q   <= '0;
            y_q   <= '0;
            r_q   <= '0;
            en_q  <= 1'b0;
            acc_q <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            r_q   <= r_d;
            en_q  <= en_d;
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q & {4{en_q}};

endmodule

`default_nettype wire

// File: rtl/collision_probe_array.sv
// +--------------------------------------------------------------------------+
// | collision_probe_array : frame-level control FSM, NUM_OBJ probe lanes and  |
// |                         the registered, coherently published hit flags.   |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module collision_probe_array
    import collider_pkg::*;
#(
    parameter int NUM_OBJ = 4,
    parameter int COORD_W = 10,
    parameter int COL_H   = 512,
    parameter int SCR_W   = 640,
    parameter int PROBE_D = 2,
    parameter int SIDE_H  = 0
) (
    input  wire logic             clk,
    input  wire logic             reset,
    collision_probe_array_if.slave bus
);
    state_t state_q, state_d;

    logic [NUM_OBJ-1:0] hit_d_q, hit_d_d, hit_u_q, hit_u_d;
    logic [NUM_OBJ-1:0] hit_l_q, hit_l_d, hit_r_q, hit_r_d;
    logic               results_valid_q, results_valid_d;

    logic               w_sample, w_publish;
    logic [3:0]         w_lane_acc [NUM_OBJ];
    logic [NUM_OBJ-1:0] w_acc_d, w_acc_u, w_acc_l, w_acc_r;

    // A column arriving together with frame_start belongs to no frame.
    assign w_sample  = bus.col_valid && (state_q == S_SCAN) && !bus.frame_start;
    assign w_publish = (state_q == S_SCAN) && bus.frame_end;

    generate
        for (genvar g = 0; g < NUM_OBJ; g++) begin : g_lane
            collision_probe_lane #(
                .COORD_W (COORD_W),
                .COL_H   (COL_H),
                .SCR_W   (SCR_W),
                .PROBE_D (PROBE_D),
                .SIDE_H  (SIDE_H)
            ) u_lane (
                .clk          (clk),
                .reset        (reset),
                .snap         (bus.frame_start),
                .sample       (w_sample),
                .obj_x        (bus.obj_x[g*COORD_W +: COORD_W]),
                .obj_y        (bus.obj_y[g*COORD_W +: COORD_W]),
                .obj_radius   (bus.obj_radius[g*COORD_W +: COORD_W]),
                .obj_en       (bus.obj_en[g]),
                .draw_x       (bus.DrawX),
                .terrain_data (bus.terrain_data),
                .acc          (w_lane_acc[g])
            );
            assign w_acc_d[g] = w_lane_acc[g][DIR_D];
            assign w_acc_u[g] = w_lane_acc[g][DIR_U];
            assign w_acc_l[g] = w_lane_acc[g][DIR_L];
            assign w_acc_r[g] = w_lane_acc[g][DIR_R];
        end
    endgenerate

    always_comb begin
        state_d         = state_q;
        hit_d_d         = hit_d_q;
        hit_u_d         = hit_u_q;
        hit_l_d         = hit_l_q;
        hit_r_d         = hit_r_q;
        results_valid_d = w_publish;

        unique case (state_q)
            S_IDLE:  if (bus.frame_start) state_d = S_SCAN;
            S_SCAN: begin
                if (bus.frame_start)    state_d = S_SCAN;
                else if (bus.frame_end) state_d = S_LATCH;
            end
            S_LATCH: state_d = bus.frame_start ? S_SCAN : S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (w_publish) begin
            hit_d_d = w_acc_d;
            hit_u_d = w_acc_u;
            hit_l_d = w_acc_l;
            hit_r_d = w_acc_r;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            hit_d_q         <= '0;
            hit_u_q         <= '0;
            hit_l_q         <= '0;
            hit_r_q         <= '0;
            results_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            hit_d_q         <= hit_d_d;
            hit_u_q         <= hit_u_d;
            hit_l_q         <= hit_l_d;
            hit_r_q         <= hit_r_d;
            results_valid_q <= results_valid_d;
        end
    end

    assign bus.hit_d         = hit_d_q;
    assign bus.hit_u         = hit_u_q;
    assign bus.hit_l         = hit_l_q;
    assign bus.hit_r         = hit_r_q;
    assign bus.results_valid = results_valid_q;
    assign bus.busy          = (state_q == S_SCAN);

endmodule

`default_nettype wire

// File: tb/tb_collision_probe_array.sv
// +--------------------------------------------------------------------------+
// | tb_collision_probe_array : two probe arrays (PROBE_D=2 and PROBE_D=1)    |
// |                            fed the same frames, checked against tables.  |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_collision_probe_array;

    localparam int NUM_OBJ = 4;
    localparam int COORD_W = 10;
    localparam int COL_H   = 512;
    localparam int SCR_W   = 640;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    collision_probe_array_if #(.NUM_OBJ(NUM_OBJ), .COORD_W(COORD_W), .COL_H(COL_H)) bus_a ();
    collision_probe_array_if #(.NUM_OBJ(NUM_OBJ), .COORD_W(COORD_W), .COL_H(COL_H)) bus_b ();

    collision_probe_array #(
        .NUM_OBJ(NUM_OBJ), .COORD_W(COORD_W), .COL_H(COL_H), .SCR_W(SCR_W),
        .PROBE_D(2), .SIDE_H(0)
    ) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));

    collision_probe_array #(
        .NUM_OBJ(NUM_OBJ), .COORD_W(COORD_W), .COL_H(COL_H), .SCR_W(SCR_W),
        .PROBE_D(1), .SIDE_H(0)
    ) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

    assign bus_b.frame_start  = bus_a.frame_start;
    assign bus_b.frame_end    = bus_a.frame_end;
    assign bus_b.col_valid    = bus_a.col_valid;
    assign bus_b.DrawX        = bus_a.DrawX;
    assign bus_b.terrain_data = bus_a.terrain_data;
    assign bus_b.obj_x        = bus_a.obj_x;
    assign bus_b.obj_y        = bus_a.obj_y;
    assign bus_b.obj_radius   = bus_a.obj_radius;
    assign bus_b.obj_en       = bus_a.obj_en;

    int total = 0;
    int bad   = 0;

    int pt_col[$];
    int pt_row[$];
    int floor_row;

    // a/b = expected lane-0 flags {r,l,u,d} for the PROBE_D=2 / PROBE_D=1 arrays
    typedef struct {
        int         x, y, r;
        int         pc, pr;
        logic [3:0] a;
        logic [3:0] b;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [COL_H-1:0] col_bits(input int col);
        logic [COL_H-1:0] v;
        v = '0;
        for (int i = 0; i < COL_H; i++) if (i >= floor_row) v[i] = 1'b1;
        for (int k = 0; k < pt_col.size(); k++) if (pt_col[k] == col) v[pt_row[k]] = 1'b1;
        return v;
    endfunction

    task automatic set_lane(input int n, input int x, input int y, input int r, input logic en);
        bus_a.obj_x[n*COORD_W +: COORD_W]      = COORD_W'(x);
        bus_a.obj_y[n*COORD_W +: COORD_W]      = COORD_W'(y);
        bus_a.obj_radius[n*COORD_W +: COORD_W] = COORD_W'(r);
        bus_a.obj_en[n]                        = en;
    endtask

    task automatic clear_scene();
        pt_col.delete();
        pt_row.delete();
        floor_row = COL_H;
        for (int n = 0; n < NUM_OBJ; n++) set_lane(n, 0, 0, 0, 1'b0);
    endtask

    task automatic start_frame(input logic with_end);
        bus_a.frame_start = 1'b1;
        bus_a.frame_end   = with_end;
        bus_a.col_valid   = 1'b0;
        tick();
        bus_a.frame_start = 1'b0;
        bus_a.frame_end   = 1'b0;
    endtask

    task automatic scan(input int first, input int last, input int chg_col, input int new_x);
        for (int c = first; c <= last; c++) begin
            if (c == chg_col) bus_a.obj_x[COORD_W-1:0] = COORD_W'(new_x);
            bus_a.col_valid    = 1'b1;
            bus_a.DrawX        = COORD_W'(c);
            bus_a.terrain_data = col_bits(c);
            tick();
        end
        bus_a.col_valid = 1'b0;
    endtask

    task automatic end_frame();
        bus_a.frame_end = 1'b1;
        tick();
        bus_a.frame_end = 1'b0;
    endtask

    task automatic chk_hits(input string tag,
                            input logic [3:0] ad, input logic [3:0] au,
                            input logic [3:0] al, input logic [3:0] ar,
                            input logic [3:0] bd, input logic [3:0] bu,
                            input logic [3:0] bl, input logic [3:0] br);
        chk({tag, " a.hit_d"}, 32'(bus_a.hit_d), 32'(ad));
        chk({tag, " a.hit_u"}, 32'(bus_a.hit_u), 32'(au));
        chk({tag, " a.hit_l"}, 32'(bus_a.hit_l), 32'(al));
        chk({tag, " a.hit_r"}, 32'(bus_a.hit_r), 32'(ar));
        chk({tag, " b.hit_d"}, 32'(bus_b.hit_d), 32'(bd));
        chk({tag, " b.hit_u"}, 32'(bus_b.hit_u), 32'(bu));
        chk({tag, " b.hit_l"}, 32'(bus_b.hit_l), 32'(bl));
        chk({tag, " b.hit_r"}, 32'(bus_b.hit_r), 32'(br));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{100, 200, 8, 100, 208, 4'b0001, 4'b0001};
        vt[1]  = '{100, 200, 8, 100, 209, 4'b0001, 4'b0000};
        vt[2]  = '{  4, 200, 8,  -1,   0, 4'b0100, 4'b0100};
        vt[3]  = '{300,   5, 8,  -1,   0, 4'b0010, 4'b0010};
        vt[4]  = '{300, 508, 8,  -1,   0, 4'b0001, 4'b0001};
        vt[5]  = '{635, 200, 8,  -1,   0, 4'b1000, 4'b1000};
        vt[6]  = '{300, 200, 8, 308, 200, 4'b1000, 4'b1000};
        vt[7]  = '{300, 200, 8, 292, 199, 4'b0000, 4'b0000};
        vt[8]  = '{300, 200, 8, 300, 191, 4'b0010, 4'b0000};
        vt[9]  = '{300, 200, 8, 300, 192, 4'b0010, 4'b0010};
        vt[10] = '{  8, 200, 8,   0, 199, 4'b0000, 4'b0000};
        vt[11] = '{632, 200, 8,  -1,   0, 4'b1000, 4'b1000};
        vt[12] = '{631, 200, 8, 639, 200, 4'b1000, 4'b1000};
        vt[13] = '{300,   8, 8,  -1,   0, 4'b0010, 4'b0000};

        reset              = 1'b1;
        bus_a.frame_start  = 1'b0;
        bus_a.frame_end    = 1'b0;
        bus_a.col_valid    = 1'b0;
        bus_a.DrawX        = '0;
        bus_a.terrain_data = '0;
        bus_a.obj_x        = '0;
        bus_a.obj_y        = '0;
        bus_a.obj_radius   = '0;
        bus_a.obj_en       = '0;
        clear_scene();
        tick();
        tick();
        chk_hits("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset rv", 32'(bus_a.results_valid), 0);
        chk("reset busy", 32'(bus_a.busy), 0);
        reset = 1'b0;
        tick();

        // Single-lane table: only lane 0 enabled, one optional solid pixel.
        for (int i = 0; i < 14; i++) begin
            clear_scene();
            set_lane(0, vt[i].x, vt[i].y, vt[i].r, 1'b1);
            if (vt[i].pc >= 0) begin
                pt_col.push_back(vt[i].pc);
                pt_row.push_back(vt[i].pr);
            end
            start_frame(1'b0);
            chk($sformatf("v%0d busy", i), 32'(bus_a.busy), 1);
            scan(0, SCR_W - 1, -1, 0);
            chk($sformatf("v%0d rv before", i), 32'(bus_a.results_valid), 0);
            end_frame();
            chk($sformatf("v%0d rv", i), 32'(bus_a.results_valid), 1);
            chk_hits($sformatf("v%0d", i),
                     {3'b0, vt[i].a[0]}, {3'b0, vt[i].a[1]}, {3'b0, vt[i].a[2]}, {3'b0, vt[i].a[3]},
                     {3'b0, vt[i].b[0]}, {3'b0, vt[i].b[1]}, {3'b0, vt[i].b[2]}, {3'b0, vt[i].b[3]});
            tick();
            chk($sformatf("v%0d rv after", i), 32'(bus_a.results_valid), 0);
        end

        // Snapshot: X moves 100->300 mid-frame, solid only at col 92 row 200.
        clear_scene();
        set_lane(0, 100, 200, 8, 1'b1);
        pt_col.push_back(92);
        pt_row.push_back(200);
        start_frame(1'b0);
        scan(0, SCR_W - 1, 20, 300);
        end_frame();
        chk_hits("snapshot", 0, 0, 4'b0001, 0, 0, 0, 4'b0001, 0);

        // Multi-lane: floor from row 300, lane 2 disabled inside the floor.
        clear_scene();
        floor_row = 300;
        set_lane(0, 100, 295, 4, 1'b1);
        set_lane(1, 200, 400, 8, 1'b1);
        set_lane(2,   2, 400, 8, 1'b0);
        set_lane(3,   4, 100, 8, 1'b1);
        start_frame(1'b0);
        scan(0, SCR_W - 1, -1, 0);
        end_frame();
        chk("multi rv", 32'(bus_a.results_valid), 1);
        chk_hits("multi", 4'b0011, 4'b0010, 4'b1010, 4'b0010,
                          4'b0010, 4'b0010, 4'b1010, 4'b0010);
        tick();

        // frame_start mid-SCAN discards the hit gathered so far, no pulse.
        clear_scene();
        set_lane(0, 100, 200, 8, 1'b1);
        pt_col.push_back(100);
        pt_row.push_back(208);
        start_frame(1'b0);
        scan(0, 150, -1, 0);
        start_frame(1'b0);
        chk("restart rv", 32'(bus_a.results_valid), 0);
        chk("restart busy", 32'(bus_a.busy), 1);
        pt_col.delete();
        pt_row.delete();
        scan(0, SCR_W - 1, -1, 0);
        end_frame();
        chk("restart pub rv", 32'(bus_a.results_valid), 1);
        chk_hits("restart", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Publish with simultaneous restart, then an empty frame.
        pt_col.push_back(100);
        pt_row.push_back(208);
        start_frame(1'b0);
        scan(0, SCR_W - 1, -1, 0);
        start_frame(1'b1);
        chk("both rv", 32'(bus_a.results_valid), 1);
        chk("both busy", 32'(bus_a.busy), 1);
        chk_hits("both", 4'b0001, 0, 0, 0, 4'b0001, 0, 0, 0);
        pt_col.delete();
        pt_row.delete();
        scan(0, SCR_W - 1, -1, 0);
        end_frame();
        chk_hits("after both", 0, 0, 0, 0, 0, 0, 0, 0);

        // LATCH + frame_start: straight back to SCAN; column with frame_start dropped.
        pt_col.push_back(100);
        pt_row.push_back(208);
        bus_a.frame_start  = 1'b1;
        bus_a.col_valid    = 1'b1;
        bus_a.DrawX        = COORD_W'(100);
        bus_a.terrain_data = col_bits(100);
        tick();
        bus_a.frame_start = 1'b0;
        bus_a.col_valid   = 1'b0;
        chk("latch->scan busy", 32'(bus_a.busy), 1);
        end_frame();
        chk("discard rv", 32'(bus_a.results_valid), 1);
        chk("discard hit_d", 32'(bus_a.hit_d), 0);
        tick();
        tick();

        // Publish a hit, then frame_end while IDLE must not pulse.
        start_frame(1'b0);
        scan(0, SCR_W - 1, -1, 0);
        end_frame();
        tick();
        tick();
        chk("idle busy", 32'(bus_a.busy), 0);
        end_frame();
        chk("idle end rv", 32'(bus_a.results_valid), 0);
        chk("idle end hold", 32'(bus_a.hit_d), 1);

        // Reset mid-SCAN clears everything without a publish.
        start_frame(1'b0);
        scan(0, 150, -1, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_hits("midreset", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("midreset rv", 32'(bus_a.results_valid), 0);
        chk("midreset busy", 32'(bus_a.busy), 0);
        end_frame();
        chk("midreset end rv", 32'(bus_a.results_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
